// File: rtl/subtractor.sv
// subtractor: pipelined inA - inB with borrow, signed overflow flag and
// valid/ready handshakes on both sides.
//
// Parameters:
//   BIT_WIDTH  operand width in bits
//   DELAY      register stages between input and output (0 = combinational)
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   inA, inB, in_valid   operation input, in_ready accepts it
//   out                  {borrow, difference}
//   ovf                  signed two's-complement overflow of the difference
//   out_valid, out_ready result handshake
// Optional build macro:
//   SUBTRACTOR_SATURATE_EN  clamp the difference to the signed range on ovf
module subtractor #(
    parameter int BIT_WIDTH = 32,
    parameter int DELAY     = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [BIT_WIDTH-1:0] inA,
    input  logic [BIT_WIDTH-1:0] inB,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [BIT_WIDTH:0]   out,
    output logic                 ovf,
    output logic                 out_valid,
    input  logic                 out_ready
);

    localparam int MSB = BIT_WIDTH - 1;

    logic [BIT_WIDTH:0] raw;
    logic [BIT_WIDTH:0] diff_c;
    logic               ovf_c;

    // The extra top bit of the widened subtraction is the unsigned borrow.
    always_comb begin
        raw    = {1'b0, inA} - {1'b0, inB};
        ovf_c  = (inA[MSB] != inB[MSB]) && (raw[MSB] != inA[MSB]);
        diff_c = raw;
`ifdef SUBTRACTOR_SATURATE_EN
        // Overflow can only push the result away from inA's sign, so the
        // clamp direction follows inA; the borrow bit is left untouched.
        if (ovf_c) begin
            diff_c[MSB:0] = inA[MSB] ? {1'b1, {(BIT_WIDTH-1){1'b0}}}
                                     : {1'b0, {(BIT_WIDTH-1){1'b1}}};
        end
`endif
    end

    generate
        if (DELAY == 0) begin : g_comb
            // Pure pass-through: clock and reset are intentionally unused.
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ rst;

            assign out       = diff_c;
            assign ovf       = ovf_c;
            assign out_valid = in_valid;
            assign in_ready  = out_ready;
        end else begin : g_pipe
            logic [DELAY-1:0]   vld_q;
            logic [DELAY-1:0]   ovf_q;
            logic [BIT_WIDTH:0] diff_q [DELAY];
            logic               adv;

            // Whole chain moves together; an empty output slot always
            // lets it advance, so bubbles drain without a consumer.
            assign adv      = out_ready || !vld_q[DELAY-1];
            assign in_ready = adv;

            always_ff @(posedge clk) begin
                if (rst) begin
                    vld_q <= '0;
                    ovf_q <= '0;
                    for (int i = 0; i < DELAY; i++) begin
                        diff_q[i] <= '0;
                    end
                end else if (adv) begin
                    vld_q[0] <= in_valid;
                    // Payload only loads with a real op; bubbles keep it.
                    if (in_valid) begin
                        diff_q[0] <= diff_c;
                        ovf_q[0]  <= ovf_c;
                    end
                    for (int i = 1; i < DELAY; i++) begin
                        vld_q[i]  <= vld_q[i-1];
                        diff_q[i] <= diff_q[i-1];
                        ovf_q[i]  <= ovf_q[i-1];
                    end
                end
            end

            assign out       = diff_q[DELAY-1];
            assign ovf       = ovf_q[DELAY-1];
            assign out_valid = vld_q[DELAY-1];
        end
    endgenerate

endmodule

// File: tb/tb_subtractor.sv
// tb_subtractor: scoreboard bench for subtractor at DELAY=2, 3 and 0
// against an arithmetic reference model.
module tb_subtractor;

    localparam int BW = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Returns {ovf, borrow, difference} from plain integer arithmetic.
    function automatic logic [BW+1:0] model(input logic [BW-1:0] a,
                                            input logic [BW-1:0] b);
        longint sa, sb, sd;
        logic [BW-1:0] d;
        logic brw, ov;
        brw = (a < b);
        d   = a - b;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        sd  = sa - sb;
        ov  = (sd > 64'sd2147483647) || (sd < -64'sd2147483648);
`ifdef SUBTRACTOR_SATURATE_EN
        if (ov) d = (sa >= 0) ? 32'h7fff_ffff : 32'h8000_0000;
`endif
        return {ov, brw, d};
    endfunction

    // ---------------- DELAY = 2 ----------------
    logic [BW-1:0] a2 = '0, b2 = '0;
    logic v2 = 1'b0, or2 = 1'b0, ir2, ovld2, ovf2;
    logic [BW:0] out2;

    subtractor #(.BIT_WIDTH(BW), .DELAY(2)) u_d2 (
        .clk(clk), .rst(rst), .inA(a2), .inB(b2),
        .in_valid(v2), .in_ready(ir2), .out(out2), .ovf(ovf2),
        .out_valid(ovld2), .out_ready(or2)
    );

    // ---------------- DELAY = 3 ----------------
    logic [BW-1:0] a3 = '0, b3 = '0;
    logic v3 = 1'b0, or3 = 1'b0, ir3, ovld3, ovf3;
    logic [BW:0] out3;

    subtractor #(.BIT_WIDTH(BW), .DELAY(3)) u_d3 (
        .clk(clk), .rst(rst), .inA(a3), .inB(b3),
        .in_valid(v3), .in_ready(ir3), .out(out3), .ovf(ovf3),
        .out_valid(ovld3), .out_ready(or3)
    );

    // ---------------- DELAY = 0 ----------------
    logic [BW-1:0] a0 = '0, b0 = '0;
    logic v0 = 1'b0, or0 = 1'b0, ir0, ovld0, ovf0;
    logic [BW:0] out0;

    subtractor #(.BIT_WIDTH(BW), .DELAY(0)) u_d0 (
        .clk(clk), .rst(rst), .inA(a0), .inB(b0),
        .in_valid(v0), .in_ready(ir0), .out(out0), .ovf(ovf0),
        .out_valid(ovld0), .out_ready(or0)
    );

    // ---------------- scoreboards ----------------
    logic [BW+1:0] exp2[$];
    logic [BW+1:0] exp3[$];
    logic          pst2 = 1'b0, pst3 = 1'b0;
    logic [BW+1:0] prv2, prv3;
    int            got3 = 0;
    int            vld2_cnt = 0;

    always @(negedge clk) begin
        logic [BW+1:0] e;
        vld2_cnt += int'(ovld2);
        if (rst) begin
            exp2.delete();
            pst2 = 1'b0;
        end else begin
            if (pst2) chk("d2_stall_hold", {ovld2, ovf2, out2},
                          {1'b1, prv2});
            if (ovld2 && !or2) chk("d2_stall_ready", ir2, 1'b0);
            if (ovld2 && or2) begin
                if (exp2.size() == 0) begin
                    chk("d2_extra_out", 1'b1, 1'b0);
                end else begin
                    e = exp2.pop_front();
                    chk("d2_out", out2, e[BW:0]);
                    chk("d2_ovf", ovf2, e[BW+1]);
                end
            end
            if (v2 && ir2) exp2.push_back(model(a2, b2));
            pst2 = ovld2 && !or2;
            prv2 = {ovf2, out2};
        end
    end

    always @(negedge clk) begin
        logic [BW+1:0] e;
        if (rst) begin
            exp3.delete();
            pst3 = 1'b0;
        end else begin
            if (pst3) chk("d3_stall_hold", {ovld3, ovf3, out3},
                          {1'b1, prv3});
            if (ovld3 && !or3) chk("d3_stall_ready", ir3, 1'b0);
            if (ovld3 && or3) begin
                got3++;
                if (exp3.size() == 0) begin
                    chk("d3_extra_out", 1'b1, 1'b0);
                end else begin
                    e = exp3.pop_front();
                    chk("d3_out", out3, e[BW:0]);
                    chk("d3_ovf", ovf3, e[BW+1]);
                end
            end
            if (v3 && ir3) exp3.push_back(model(a3, b3));
            pst3 = ovld3 && !or3;
            prv3 = {ovf3, out3};
        end
    end

    // One op through DELAY=2 with exact-latency and constant checks.
    task automatic dir2(input logic [BW-1:0] a, input logic [BW-1:0] b,
                        input logic [BW:0] eo, input logic eov);
        a2 = a; b2 = b; v2 = 1'b1; or2 = 1'b1;
        @(posedge clk); #1;
        v2 = 1'b0;
        chk("d2_lat_early", ovld2, 1'b0);
        @(posedge clk); #1;
        chk("d2_lat_valid", ovld2, 1'b1);
        chk("d2_dir_out", out2, eo);
        chk("d2_dir_ovf", ovf2, eov);
    endtask

    logic [BW-1:0] corner [6];
    initial begin
        corner[0] = '0;           corner[1] = 32'h0000_0001;
        corner[2] = 32'h7fff_ffff; corner[3] = 32'h8000_0000;
        corner[4] = 32'hffff_ffff; corner[5] = 32'h8000_0001;
    end

    function automatic logic [BW-1:0] pick();
        if ($urandom_range(0, 2) == 0) return corner[$urandom_range(0, 5)];
        return $urandom();
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [BW+1:0] m;
        int  i, cyc;
        logic hs;

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_d2_valid", ovld2, 1'b0);
        chk("rst_d2_out", out2, '0);
        chk("rst_d2_ovf", ovf2, 1'b0);
        chk("rst_d2_ready", ir2, 1'b1);
        chk("rst_d3_valid", ovld3, 1'b0);
        chk("rst_d3_out", out3, '0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Directed DELAY=2 vectors.
        dir2(32'd10, 32'd3, 33'h0_0000_0007, 1'b0);
        dir2(32'd3, 32'd10, 33'h1_ffff_fff9, 1'b0);
`ifdef SUBTRACTOR_SATURATE_EN
        dir2(32'h8000_0000, 32'd1, 33'h0_8000_0000, 1'b1);
        dir2(32'h7fff_ffff, 32'hffff_ffff, 33'h1_7fff_ffff, 1'b1);
`else
        dir2(32'h8000_0000, 32'd1, 33'h0_7fff_ffff, 1'b1);
        dir2(32'h7fff_ffff, 32'hffff_ffff, 33'h1_8000_0000, 1'b1);
`endif
        dir2(32'hffff_ffff, 32'hffff_ffff, 33'h0_0000_0000, 1'b0);
        dir2(32'h0, 32'hffff_ffff, 33'h1_0000_0001, 1'b0);

        // Random DELAY=2 traffic with random backpressure.
        for (int k = 0; k < 400; k++) begin
            a2  = pick();
            b2  = pick();
            v2  = ($urandom_range(0, 3) != 0);
            or2 = ($urandom_range(0, 2) != 0);
            @(posedge clk); #1;
        end
        v2 = 1'b0; or2 = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("d2_drained", exp2.size(), 0);

        // Reset with two ops in flight.
        a2 = 32'd50; b2 = 32'd8; v2 = 1'b1;
        @(posedge clk); #1;
        a2 = 32'd60; b2 = 32'd9;
        @(posedge clk); #1;
        v2 = 1'b0; or2 = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_valid", ovld2, 1'b0);
        chk("midrst_out", out2, '0);
        chk("midrst_ovf", ovf2, 1'b0);
        or2 = 1'b1;
        vld2_cnt = 0;
        repeat (8) @(posedge clk);
        #1;
        chk("midrst_no_stale", vld2_cnt, 0);

        // DELAY=3 stream of ten ops under random backpressure.
        i = 0; cyc = 0;
        a3 = 32'd100; b3 = 32'd0; v3 = 1'b1;
        while ((i < 10 || got3 < 10) && cyc < 1000) begin
            or3 = ($urandom_range(0, 1) != 0);
            @(negedge clk);
            hs = v3 && ir3;
            @(posedge clk); #1;
            if (hs) begin
                i++;
                if (i < 10) begin
                    a3 = 32'(i + 100);
                    b3 = 32'(i);
                end else begin
                    v3 = 1'b0;
                end
            end
            cyc++;
        end
        or3 = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("d3_count", got3, 10);
        chk("d3_drained", exp3.size(), 0);

        // DELAY=0 combinational path.
        a0 = 32'd5; b0 = 32'd5; v0 = 1'b1; or0 = 1'b0;
        #1;
        chk("d0_valid", ovld0, 1'b1);
        chk("d0_out", out0, '0);
        chk("d0_ready", ir0, 1'b0);
        for (int k = 0; k < 30; k++) begin
            a0  = pick();
            b0  = pick();
            v0  = ($urandom_range(0, 1) != 0);
            or0 = ($urandom_range(0, 1) != 0);
            m   = model(a0, b0);
            #1;
            chk("d0_rand_out", out0, m[BW:0]);
            chk("d0_rand_ovf", ovf0, m[BW+1]);
            chk("d0_rand_valid", ovld0, v0);
            chk("d0_rand_ready", ir0, or0);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/subtractor.md
Name: subtractor

Overview:
- Pipelined subtractor and the arithmetic complement of the datapath adder: computes inA - inB with a borrow bit.
- Uses the same BIT_WIDTH/DELAY parameter set and the same {borrow/carry, result} output width as the adder.
- Adds a valid/ready handshake on both sides so it can sit in the ALU/branch-compare path and absorb backpressure from downstream stages.

Parameters:
- BIT_WIDTH, 32, operand width in bits.
- DELAY, 0, number of register stages between input and output. 0 means a combinational pass-through.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- inA  input  BIT_WIDTH  minuend.
- inB  input  BIT_WIDTH  subtrahend.
- in_valid  input  1  inA/inB hold a valid operation.
- in_ready  output  1  block accepts an operation this cycle.
- out  output  BIT_WIDTH+1  {borrow, difference}.
- ovf  output  1  signed two's-complement overflow of the difference.
- out_valid  output  1  out/ovf hold a valid result.
- out_ready  input  1  downstream accepts the result this cycle.

Behaviour:
- Arithmetic:
  - out = ({1'b0,inA} - {1'b0,inB}) mod 2^(BIT_WIDTH+1).
  - out[BIT_WIDTH] = 1 exactly when inA < inB, compared unsigned.
  - ovf = (inA[MSB] != inB[MSB]) && (out[BIT_WIDTH-1] != inA[MSB]).
- Handshake:
  - An input transfer occurs when in_valid && in_ready.
  - An output transfer occurs when out_valid && out_ready.
  - Data, ovf and out_valid are held stable while out_valid=1 and out_ready=0.
- DELAY=0:
  - No state. out_valid = in_valid, in_ready = out_ready.
  - out/ovf are combinational from inA/inB.
  - rst has no effect.
- DELAY>=1:
  - A chain of DELAY stages; each stage holds a valid bit, a diff register and an ovf register.
  - The subtraction is computed in front of stage 1; later stages only carry it forward.
  - Global advance enable: adv = out_ready || !out_valid.
  - in_ready = adv, combinational.
  - On adv, every stage shifts forward by one. Stage 1 loads valid = in_valid and the computed result. The payload loads only when in_valid=1; otherwise it holds the old value and the valid bit is 0 (a bubble).
  - When adv=0, all stages hold.
  - out_valid and out/ovf come from the last stage.
- Latency: exactly DELAY cycles from input transfer to out_valid when no stalls occur. Throughput is one op per cycle.
- Bubbles are not collapsed. A bubble in the last stage with out_valid=0 still advances, because adv=1.
- Reset (DELAY>=1):
  - All valid bits clear to 0; out, ovf and all diff registers clear to 0.
  - in_ready reads 1 during reset, since out_valid=0, but a transfer accepted in a reset cycle is discarded.
  - Reset mid-operation drops all in-flight results; there is no partial output.
- Simultaneous in/out transfer on a full pipeline: both occur, and occupancy is unchanged.
- Operands wrap modulo 2^BIT_WIDTH. There are no exceptions and no other status outputs.

Optional Feature:
- Macro: SUBTRACTOR_SATURATE_EN.
- Defined:
  - When ovf=1, out[BIT_WIDTH-1:0] is replaced by a saturated value. If inA is non-negative (inA[MSB]=0) it is 0x7FF..F; otherwise it is 0x800..0.
  - out[BIT_WIDTH] still reports the unsigned borrow, and ovf still reports the raw overflow.
  - Saturation is applied before stage 1, so latency is unchanged.
- Undefined: wrap-around result, no saturation logic is synthesised.

Test Plan:
- BIT_WIDTH=32, DELAY=2, out_ready=1: inA=10, inB=3 -> after 2 cycles out_valid=1, out=0x0_00000007, ovf=0.
- DELAY=2: inA=3, inB=10 -> out=0x1_FFFFFFF9 (borrow=1), ovf=0.
- DELAY=2, macro undefined: inA=0x80000000, inB=1 -> out=0x0_7FFFFFFF, ovf=1.
  - With SUBTRACTOR_SATURATE_EN defined, the same stimulus -> out[31:0]=0x80000000, ovf=1.
- DELAY=3 backpressure: stream inA=i+100, inB=i for i=0..9 with out_ready toggled randomly -> exactly 10 results, all =100, in order. Outputs stay stable while stalled, and in_ready=0 whenever out_valid=1 and out_ready=0.
- DELAY=2: load 2 ops, assert rst for 1 cycle mid-flight -> out_valid=0 and out=0 the next cycle, and no stale result ever appears afterwards.
- DELAY=0: in_valid=1, inA=5, inB=5, out_ready=0 -> same cycle out_valid=1, out=0, in_ready=0.
